// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode map, FSM states, width defaults.
// The ALU_ARB_FLAGS_EN build option lives in the interface and top-level files.
package alu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ASR  = 4'h6;
  localparam logic [3:0] OP_PASB = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_NAND = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_PASA = 4'hE;
  localparam logic [3:0] OP_NOTA = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// ALU_ARB_FLAGS_EN adds per-requester zero/carry response flags.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4
);
  logic              req_valid_0, req_ready_0;
  logic [OP_W-1:0]   req_op_0;
  logic [DATA_W-1:0] req_a_0, req_b_0;
  logic              req_valid_1, req_ready_1;
  logic [OP_W-1:0]   req_op_1;
  logic [DATA_W-1:0] req_a_1, req_b_1;
  logic              rsp_valid_0, rsp_ready_0;
  logic [DATA_W-1:0] rsp_res_0;
  logic              rsp_valid_1, rsp_ready_1;
  logic [DATA_W-1:0] rsp_res_1;
  logic              busy;
`ifdef ALU_ARB_FLAGS_EN
  logic              rsp_zero_0, rsp_carry_0;
  logic              rsp_zero_1, rsp_carry_1;
`endif

  modport master (
`ifdef ALU_ARB_FLAGS_EN
    input  rsp_zero_0, rsp_carry_0, rsp_zero_1, rsp_carry_1,
`endif
    output req_valid_0, req_op_0, req_a_0, req_b_0,
    output req_valid_1, req_op_1, req_a_1, req_b_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_res_0, rsp_valid_1, rsp_res_1,
    input  busy
  );

  modport slave (
`ifdef ALU_ARB_FLAGS_EN
    output rsp_zero_0, rsp_carry_0, rsp_zero_1, rsp_carry_1,
`endif
    input  req_valid_0, req_op_0, req_a_0, req_b_0,
    input  req_valid_1, req_op_1, req_a_1, req_b_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_res_0, rsp_valid_1, rsp_res_1,
    output busy
  );
endinterface

// File: rtl/alu_req_arbiter_core.sv
// alu4_core: 16-function combinational ALU; carry is carry-out on ADD, borrow on SUB, else 0.
module alu4_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] dif_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  begin res = sum_ext[DATA_W-1:0]; carry = sum_ext[DATA_W]; end
      OP_SUB:  begin res = dif_ext[DATA_W-1:0]; carry = dif_ext[DATA_W]; end
      OP_INC:  res = a + DATA_W'(1);
      OP_DEC:  res = a - DATA_W'(1);
      OP_SHL:  res = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  res = {1'b0, a[DATA_W-1:1]};
      OP_ASR:  res = {a[DATA_W-1], a[DATA_W-1:1]};
      OP_PASB: res = b;
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_PASA: res = a;
      OP_NOTA: res = ~a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end to a single shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FLAGS_EN to add registered zero/carry flags to each response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_req_arbiter_if.slave  bus
);

  state_t            state;
  logic              gnt;
  logic              ptr;
  logic              sel;
  logic              any_vld;
  logic              idle_ok;
  logic              rsp_rdy_g;
  logic              rsp_vld_0, rsp_vld_1;
  logic [OP_W-1:0]   op_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [DATA_W-1:0] res_p1;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
`ifdef ALU_ARB_FLAGS_EN
  logic              zero_p1, carry_p1;
`else
  logic              unused_carry;
  assign unused_carry = alu_carry;
`endif

  // Pointer only breaks ties; a lone requester always wins.
  assign any_vld = bus.req_valid_0 | bus.req_valid_1;
  assign sel     = (bus.req_valid_0 & bus.req_valid_1) ? ptr : bus.req_valid_1;
  assign idle_ok = rst_n && (state == ST_IDLE);

  assign bus.req_ready_0 = idle_ok & bus.req_valid_0 & ~sel;
  assign bus.req_ready_1 = idle_ok & bus.req_valid_1 & sel;

  assign rsp_rdy_g = gnt ? bus.rsp_ready_1 : bus.rsp_ready_0;

  alu4_core #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op    (op_p0),
    .a     (a_p0),
    .b     (b_p0),
    .res   (alu_res),
    .carry (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gnt    <= 1'b0;
      ptr    <= 1'b0;
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      res_p1 <= '0;
`ifdef ALU_ARB_FLAGS_EN
      zero_p1  <= 1'b0;
      carry_p1 <= 1'b0;
`endif
    end else begin
      case (state)
        // p0: capture the granted requester's operands
        ST_IDLE: begin
          if (any_vld) begin
            op_p0 <= sel ? bus.req_op_1 : bus.req_op_0;
            a_p0  <= sel ? bus.req_a_1  : bus.req_a_0;
            b_p0  <= sel ? bus.req_b_1  : bus.req_b_0;
            gnt   <= sel;
            state <= ST_EXEC;
          end
        end
        // p1: register the ALU result
        ST_EXEC: begin
          res_p1 <= alu_res;
`ifdef ALU_ARB_FLAGS_EN
          zero_p1  <= (alu_res == '0);
          carry_p1 <= alu_carry;
`endif
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_rdy_g) begin
            ptr   <= ~gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_vld_0 = (state == ST_RESP) & ~gnt;
  assign rsp_vld_1 = (state == ST_RESP) &  gnt;

  assign bus.rsp_valid_0 = rsp_vld_0;
  assign bus.rsp_valid_1 = rsp_vld_1;
  assign bus.rsp_res_0   = rsp_vld_0 ? res_p1 : '0;
  assign bus.rsp_res_1   = rsp_vld_1 ? res_p1 : '0;
  assign bus.busy        = (state != ST_IDLE);

`ifdef ALU_ARB_FLAGS_EN
  assign bus.rsp_zero_0  = rsp_vld_0 & zero_p1;
  assign bus.rsp_carry_0 = rsp_vld_0 & carry_p1;
  assign bus.rsp_zero_1  = rsp_vld_1 & zero_p1;
  assign bus.rsp_carry_1 = rsp_vld_1 & carry_p1;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a response scoreboard; flag checks follow ALU_ARB_FLAGS_EN.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.DATA_W(4), .OP_W(4)) bus ();
  alu_req_arbiter #(.DATA_W(4), .OP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       id;
    logic [3:0] res;
    logic       zero;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid_0 = 1'b0; bus.req_op_0 = '0; bus.req_a_0 = '0; bus.req_b_0 = '0;
    bus.req_valid_1 = 1'b0; bus.req_op_1 = '0; bus.req_a_1 = '0; bus.req_b_1 = '0;
  endtask

  task automatic drive_req(input logic id, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b);
    if (id == 1'b0) begin
      bus.req_valid_0 = 1'b1; bus.req_op_0 = op; bus.req_a_0 = a; bus.req_b_0 = b;
    end else begin
      bus.req_valid_1 = 1'b1; bus.req_op_1 = op; bus.req_a_1 = a; bus.req_b_1 = b;
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [3:0] res, input logic carry);
    exp_t e;
    e.id    = id;
    e.res   = res;
    e.zero  = (res == 4'h0);
    e.carry = carry;
    sb.push_back(e);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic take_rsp(input logic id);
    exp_t e;
    int   n;
    logic v;
    n = 0;
    @(negedge clk);
    v = id ? bus.rsp_valid_1 : bus.rsp_valid_0;
    while (!v && n < 8) begin
      @(negedge clk);
      n++;
      v = id ? bus.rsp_valid_1 : bus.rsp_valid_0;
    end
    if (!v) chk("rsp_timeout", 0, 1);
    else if (sb.size() == 0) chk("sb_underflow", 0, 1);
    else begin
      e = sb.pop_front();
      chk("rsp_id", id, e.id);
      chk("rsp_res", id ? bus.rsp_res_1 : bus.rsp_res_0, e.res);
      chk("rsp_other_valid", id ? bus.rsp_valid_0 : bus.rsp_valid_1, 0);
      chk("rsp_other_res", id ? bus.rsp_res_0 : bus.rsp_res_1, 0);
`ifdef ALU_ARB_FLAGS_EN
      chk("rsp_zero", id ? bus.rsp_zero_1 : bus.rsp_zero_0, e.zero);
      chk("rsp_carry", id ? bus.rsp_carry_1 : bus.rsp_carry_0, e.carry);
`endif
    end
    if (id) bus.rsp_ready_1 = 1'b1;
    else    bus.rsp_ready_0 = 1'b1;
    next_edge();
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready_0"}, bus.req_ready_0, 0);
    chk({tag, "_req_ready_1"}, bus.req_ready_1, 0);
    chk({tag, "_rsp_valid_0"}, bus.rsp_valid_0, 0);
    chk({tag, "_rsp_valid_1"}, bus.rsp_valid_1, 0);
    chk({tag, "_rsp_res_0"}, bus.rsp_res_0, 0);
    chk({tag, "_rsp_res_1"}, bus.rsp_res_1, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    clear_reqs();
    #2 rst_n = 1'b1;
    next_edge();

    // Lone requester 0, NOR; response two edges after the acceptance cycle
    drive_req(0, OP_NOR, 4'b1010, 4'b0100);
    @(negedge clk);
    chk("t1_ready_0", bus.req_ready_0, 1);
    chk("t1_ready_1", bus.req_ready_1, 0);
    expect_rsp(0, 4'b0001, 0);
    next_edge();
    clear_reqs();
    @(negedge clk);
    chk("t1_rsp_valid_early", bus.rsp_valid_0, 0);
    chk("t1_busy", bus.busy, 1);
    next_edge();
    @(negedge clk);
    chk("t1_rsp_valid_latency", bus.rsp_valid_0, 1);
    take_rsp(0);

    // Lone requester 1, AND; leaves pointer at 0
    drive_req(1, OP_AND, 4'b1100, 4'b1010);
    @(negedge clk);
    chk("t2_ready_1", bus.req_ready_1, 1);
    chk("t2_ready_0", bus.req_ready_0, 0);
    expect_rsp(1, 4'b1000, 0);
    next_edge();
    clear_reqs();
    take_rsp(1);

    // Both valid with pointer 0: 0 first, then 1
    drive_req(0, OP_ADD, 4'd3, 4'd4);
    drive_req(1, OP_SUB, 4'd5, 4'd2);
    @(negedge clk);
    chk("t3_ready_0", bus.req_ready_0, 1);
    chk("t3_ready_1", bus.req_ready_1, 0);
    expect_rsp(0, 4'd7, 0);
    next_edge();
    bus.req_valid_0 = 1'b0;
    @(negedge clk);
    chk("t3_ready_1_exec", bus.req_ready_1, 0);
    take_rsp(0);
    @(negedge clk);
    chk("t3_ready_1_idle", bus.req_ready_1, 1);
    expect_rsp(1, 4'd3, 0);
    next_edge();
    clear_reqs();
    take_rsp(1);

    // Pointer back at 0; stall response 0 for five cycles while 1 waits
    drive_req(0, OP_OR, 4'b0011, 4'b0100);
    drive_req(1, OP_SUB, 4'd4, 4'd4);
    @(negedge clk);
    chk("t4_ready_0", bus.req_ready_0, 1);
    chk("t4_ready_1", bus.req_ready_1, 0);
    expect_rsp(0, 4'b0111, 0);
    next_edge();
    bus.req_valid_0 = 1'b0;
    next_edge();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", bus.rsp_valid_0, 1);
      chk("t4_stall_res", bus.rsp_res_0, 4'b0111);
      chk("t4_stall_ready_1", bus.req_ready_1, 0);
    end
    take_rsp(0);
    @(negedge clk);
    chk("t4_accept_1", bus.req_ready_1, 1);
    expect_rsp(1, 4'h0, 0);
    next_edge();
    clear_reqs();
    take_rsp(1);

    // ADD with carry-out
    drive_req(0, OP_ADD, 4'd9, 4'd8);
    @(negedge clk);
    chk("t5_ready_0", bus.req_ready_0, 1);
    expect_rsp(0, 4'h1, 1);
    next_edge();
    clear_reqs();
    take_rsp(0);

    // Reset during EXEC with pointer at 1: operation dropped, pointer back to 0
    drive_req(0, OP_SUB, 4'd5, 4'd2);
    @(negedge clk);
    chk("t6_ready_0", bus.req_ready_0, 1);
    next_edge();
    clear_reqs();
    @(negedge clk);
    chk("t6_busy_exec", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    bus.req_valid_0 = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready_0", bus.req_ready_0, 0);
    clear_reqs();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp_0", bus.rsp_valid_0, 0);
      chk("t6_no_rsp_1", bus.rsp_valid_1, 0);
    end
    next_edge();
    drive_req(0, OP_ADD, 4'd2, 4'd2);
    drive_req(1, OP_OR, 4'b1000, 4'b0001);
    @(negedge clk);
    chk("t6_ptr0_ready_0", bus.req_ready_0, 1);
    chk("t6_ptr0_ready_1", bus.req_ready_1, 0);
    expect_rsp(0, 4'd4, 0);
    next_edge();
    bus.req_valid_0 = 1'b0;
    take_rsp(0);
    @(negedge clk);
    chk("t6_ready_1", bus.req_ready_1, 1);
    expect_rsp(1, 4'b1001, 0);
    next_edge();
    clear_reqs();
    take_rsp(1);

    // Requester 1 withdraws while 0 is in service
    drive_req(0, OP_AND, 4'b1111, 4'b0110);
    @(negedge clk);
    chk("t7_ready_0", bus.req_ready_0, 1);
    expect_rsp(0, 4'b0110, 0);
    next_edge();
    clear_reqs();
    drive_req(1, OP_ADD, 4'd1, 4'd1);
    @(negedge clk);
    chk("t7_ready_1_exec", bus.req_ready_1, 0);
    next_edge();
    @(negedge clk);
    chk("t7_ready_1_resp", bus.req_ready_1, 0);
    clear_reqs();
    take_rsp(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t7_no_rsp_1", bus.rsp_valid_1, 0);
      chk("t7_idle", bus.busy, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
